lcd_receiver: RTL
=================

LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 Parameters SHALL be: BUSY_CYCLES, 4, cycles o_busy stays high after an accepted non-clear write (legal range 1..255).
REQ-002 Parameters SHALL be: BLANK_CHAR, 8'h20, fill value written by a clear command.
REQ-003 Port i_clk SHALL be: input, 1, single clock; all state updates on its rising edge.
REQ-004 Port i_reset SHALL be: input, 1, synchronous active-high reset.
REQ-005 Port i_io_lcd SHALL be: input, 32, LCD register word from the core, same clock domain. Fields: [31] ON, [10] EN, [9] RS (0=cmd, 1=data), [8] RW (1=read), [7:0] DATA.
REQ-006 Port i_rd_addr SHALL be: input, 5, display-buffer read index (row = [4], col = [3:0]).
REQ-007 Port o_rd_data SHALL be: output, 8, buffer byte at i_rd_addr; combinational read.
REQ-008 Port o_on SHALL be: output, 1, registered copy of i_io_lcd[31].
REQ-009 Port o_busy SHALL be: output, 1, high whenever state is not IDLE.
REQ-010 Port o_cursor SHALL be: output, 5, current write index {row, col}.
REQ-011 Port o_wr_cnt SHALL be: output, 16, count of accepted writes; saturates at 16'hFFFF.
REQ-012 Port o_drop_err SHALL be: output, 1, sticky flag; set when a write strobe arrives while busy.

Function
REQ-013 The block SHALL register i_io_lcd[10] every cycle and detect a strobe as registered EN = 1 and current EN = 0 (falling edge).
REQ-014 A strobe with ON = 0 or RW = 1 SHALL be ignored: no state change, no count, no error.
REQ-015 A qualifying strobe SHALL latch RS and DATA from the same cycle in which EN is seen low.
REQ-016 The FSM SHALL have three states: IDLE, BUSY and CLEAR.
REQ-017 In IDLE, a qualifying strobe SHALL be accepted: o_wr_cnt increments, and the next state is CLEAR for command 8'h01, otherwise BUSY.
REQ-018 A data write (RS = 1) SHALL store DATA at o_cursor on the accept edge. The cursor then increments modulo 32: 0x0F goes to 0x10, and 0x1F wraps to 0x00.
REQ-019 Command 8'h01 (clear) SHALL set the cursor to 0 and enter CLEAR.
  - CLEAR writes BLANK_CHAR to index k in the k-th CLEAR cycle, for k = 0..31.
  - After exactly 32 cycles the FSM returns to IDLE.
REQ-020 Command 8'h02 or 8'h03 (home) SHALL set the cursor to 0 without modifying the buffer.
REQ-021 A command with DATA[7] = 1 (set address) SHALL set the cursor to {DATA[6], DATA[3:0]}.
REQ-022 All other commands SHALL be accepted (counted and made busy) but SHALL have no effect on the cursor or buffer.
REQ-023 BUSY SHALL last exactly BUSY_CYCLES cycles, then return to IDLE. The BUSY-cycle down-counter is 8 bits wide.
REQ-024 A qualifying strobe in BUSY or CLEAR SHALL be dropped: o_drop_err is set, nothing else changes, and the FSM timer is unaffected.
REQ-025 The first cycle back in IDLE SHALL accept a strobe detected that same cycle.
REQ-026 o_rd_data SHALL reflect a buffer write from the following cycle onward. A read-during-write at the same index returns the old value.

Reset
REQ-027 While i_reset is high at a clock edge, the block SHALL force the following:
  - FSM = IDLE.
  - o_busy = 0, o_cursor = 0, o_wr_cnt = 0, o_drop_err = 0, o_on = 0.
  - Registered EN = 0.
  - All 32 buffer bytes = BLANK_CHAR, completed within the reset cycle.
REQ-028 Reset asserted mid-CLEAR or mid-BUSY SHALL abort the operation and take precedence over any same-cycle strobe.
REQ-029 A strobe whose EN-high cycle overlaps reset SHALL NOT be detected after reset releases.

Verification
REQ-030 After reset, ON = 1, RS = 1: write bytes 'H' (8'h48) then 'I' (8'h49), each pulse spaced beyond BUSY_CYCLES.
  - Required: buffer[0] = 8'h48, buffer[1] = 8'h49, o_cursor = 2, o_wr_cnt = 2.
REQ-031 Command 8'hC5 then data 8'h41.
  - Required: buffer[21] = 8'h41 and o_cursor = 22.
REQ-032 Cursor at 31, data 8'h5A.
  - Required: buffer[31] = 8'h5A and o_cursor = 0.
REQ-033 Command 8'h01.
  - Required: o_busy high for exactly 32 cycles, all 32 bytes read 8'h20, o_cursor = 0.
REQ-034 Second strobe issued 1 cycle after an accepted write (BUSY_CYCLES = 4).
  - Required: second write dropped, o_drop_err = 1, o_wr_cnt unchanged by it.
  - Required: a strobe with ON = 0 or RW = 1 changes nothing.
REQ-035 Reset asserted at CLEAR cycle 10.
  - Required: next cycle o_busy = 0, o_cursor = 0, all bytes 8'h20, o_wr_cnt = 0.

Source files
------------

// File: rtl/lcd_if.sv
// Bundle between the core's LCD register and the receiver, plus the display-buffer read port.
// Strobe semantics: a write is offered when EN falls (EN high in one cycle, low the next); there is
// no ready, and a write offered while o_busy is high is dropped and latched in o_drop_err.
interface lcd_if;
  logic [31:0] i_io_lcd;
  logic [4:0]  i_rd_addr;
  logic [7:0]  o_rd_data;
  logic        o_on;
  logic        o_busy;
  logic [4:0]  o_cursor;
  logic [15:0] o_wr_cnt;
  logic        o_drop_err;
  logic [1:0]  o_state;

  modport master (
    output i_io_lcd, i_rd_addr,
    input  o_rd_data, o_on, o_busy, o_cursor, o_wr_cnt, o_drop_err, o_state
  );

  modport slave (
    input  i_io_lcd, i_rd_addr,
    output o_rd_data, o_on, o_busy, o_cursor, o_wr_cnt, o_drop_err, o_state
  );
endinterface

// File: rtl/lcd_receiver.sv
// HD44780-style write receiver: decodes EN falling-edge strobes into a 2x16 display buffer,
// with a fixed busy period after each write and a 32-cycle sequential clear.
module lcd_receiver #(
  parameter int          BUSY_CYCLES = 4,
  parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
  input  logic i_clk,
  input  logic i_reset,
  lcd_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYCLES - 1);

  logic [1:0]  state;
  logic        en_q;
  logic [7:0]  timer;
  logic [4:0]  clr_idx;
  logic [4:0]  cursor;
  logic [15:0] wr_cnt;
  logic        drop_err;
  logic        on_q;
  logic [7:0]  mem [32];

  logic       lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
  logic       strobe, write_req, accept;

  assign lcd_on   = bus.i_io_lcd[31];
  assign lcd_en   = bus.i_io_lcd[10];
  assign lcd_rs   = bus.i_io_lcd[9];
  assign lcd_rw   = bus.i_io_lcd[8];
  assign lcd_data = bus.i_io_lcd[7:0];

  // RS/DATA are taken from the cycle where EN is already low.
  assign strobe    = en_q & ~lcd_en;
  assign write_req = strobe & lcd_on & ~lcd_rw;
  assign accept    = write_req & (state == ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      en_q     <= 1'b0;
      timer    <= 8'd0;
      clr_idx  <= 5'd0;
      cursor   <= 5'd0;
      wr_cnt   <= 16'd0;
      drop_err <= 1'b0;
      on_q     <= 1'b0;
      for (int i = 0; i < 32; i++) mem[i] <= BLANK_CHAR;
    end else begin
      en_q <= lcd_en;
      on_q <= lcd_on;
      if (write_req && (state != ST_IDLE)) drop_err <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            timer <= BUSY_LOAD;
            state <= ST_BUSY;
            if (lcd_rs) begin
              mem[cursor] <= lcd_data;
              cursor      <= cursor + 5'd1;
            end else if (lcd_data == 8'h01) begin
              cursor  <= 5'd0;
              clr_idx <= 5'd0;
              state   <= ST_CLEAR;
            end else if ((lcd_data == 8'h02) || (lcd_data == 8'h03)) begin
              cursor <= 5'd0;
            end else if (lcd_data[7]) begin
              cursor <= {lcd_data[6], lcd_data[3:0]};
            end
          end
        end
        ST_BUSY: begin
          if (timer == 8'd0) state <= ST_IDLE;
          else               timer <= timer - 8'd1;
        end
        ST_CLEAR: begin
          mem[clr_idx] <= BLANK_CHAR;
          clr_idx      <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_rd_data  = mem[bus.i_rd_addr];
  assign bus.o_on       = on_q;
  assign bus.o_busy     = (state != ST_IDLE);
  assign bus.o_cursor   = cursor;
  assign bus.o_wr_cnt   = wr_cnt;
  assign bus.o_drop_err = drop_err;
  assign bus.o_state    = state;
endmodule
